// File: rtl/ah_arb_pkg.sv
// Shared types and default sizing for the weighted round-robin burst scheduler.
package ah_arb_pkg;

   localparam int unsigned DEF_NUM_CLIENTS = 4;
   localparam int unsigned DEF_WEIGHT_W    = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ah_rr_pick.sv
// Rotating-priority picker: first set bit of elig searching from ptr upward, wrapping.
module ah_rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     elig,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W-1:0] cand;

   // N is a power of two, so the index addition wraps naturally.
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      cand   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = ptr + IDX_W'(i);
         if (!any && elig[cand]) begin
            any          = 1'b1;
            idx          = cand;
            onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ah_wrr_burst_sched.sv
// Weighted round-robin burst scheduler: credit-limited, non-preemptive bursts
// from NUM_CLIENTS requesters onto one shared beat port.
module ah_wrr_burst_sched
   import ah_arb_pkg::*;
#(
   parameter  int unsigned NUM_CLIENTS = DEF_NUM_CLIENTS,
   parameter  int unsigned WEIGHT_W    = DEF_WEIGHT_W,
   localparam int unsigned IDX_W       = $clog2(NUM_CLIENTS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_CLIENTS-1:0]          req_valid,
   input  logic [NUM_CLIENTS-1:0]          req_last,
   output logic [NUM_CLIENTS-1:0]          req_ready,
   input  logic [NUM_CLIENTS*WEIGHT_W-1:0] cfg_weight,
   output logic                            out_valid,
   output logic                            out_last,
   input  logic                            out_ready,
   output logic [IDX_W-1:0]                out_src,
   output logic [NUM_CLIENTS-1:0]          gnt,
   output logic                            busy
);

   arb_state_t             state_q, state_d;
   logic [NUM_CLIENTS-1:0] gnt_q;
   logic [IDX_W-1:0]       src_q;
   logic [IDX_W-1:0]       ptr_q;
   logic [WEIGHT_W-1:0]    cnt_q [NUM_CLIENTS];

   logic [NUM_CLIENTS-1:0] elig;
   logic [NUM_CLIENTS-1:0] pick_onehot;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_any;
   logic                   grant;
   logic                   refresh;
   logic                   last_beat;

   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         elig[i] = req_valid[i] && (cnt_q[i] != '0);
      end
   end

   ah_rr_pick #(
      .N     (NUM_CLIENTS),
      .IDX_W (IDX_W)
   ) u_pick (
      .elig   (elig),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Credits are reloaded only when someone is waiting but nobody is eligible.
   assign grant     = (state_q == ST_IDLE) && pick_any;
   assign refresh   = (state_q == ST_IDLE) && !pick_any && (|req_valid);
   assign last_beat = (state_q == ST_BURST) && out_valid && out_last && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (pick_any)  state_d = ST_BURST;
         ST_BURST: if (last_beat) state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      out_last  = 1'b0;
      req_ready = '0;
      busy      = (state_q == ST_BURST);
      if (state_q == ST_BURST) begin
         out_valid        = req_valid[src_q];
         out_last         = req_last[src_q];
         req_ready[src_q] = out_ready;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q <= '0;
         src_q <= '0;
         ptr_q <= '0;
         for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         if (grant) begin
            gnt_q <= pick_onehot;
            src_q <= pick_idx;
         end else if (last_beat) begin
            gnt_q        <= '0;
            ptr_q        <= src_q + IDX_W'(1);
            cnt_q[src_q] <= (cnt_q[src_q] != '0) ? cnt_q[src_q] - WEIGHT_W'(1) : '0;
         end
         if (refresh) begin
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
               cnt_q[i] <= cfg_weight[i*WEIGHT_W +: WEIGHT_W];
            end
         end
      end
   end

   assign gnt     = gnt_q;
   assign out_src = src_q;

endmodule

// File: tb/tb_ah_wrr_burst_sched.sv
// Scoreboard bench for ah_wrr_burst_sched: per-client burst drivers, expected
// beats (source, last flag, spacing) queued per scenario and popped on handshake.
module tb_ah_wrr_burst_sched;

   localparam int NC = 4;
   localparam int WW = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NC-1:0]    req_valid;
   logic [NC-1:0]    req_last;
   logic [NC-1:0]    req_ready;
   logic [NC*WW-1:0] cfg_weight;
   logic             out_valid;
   logic             out_last;
   logic             out_ready;
   logic [1:0]       out_src;
   logic [NC-1:0]    gnt;
   logic             busy;

   always #5 clk = ~clk;

   ah_wrr_burst_sched #(
      .NUM_CLIENTS (NC),
      .WEIGHT_W    (WW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .cfg_weight (cfg_weight),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .out_src    (out_src),
      .gnt        (gnt),
      .busy       (busy)
   );

   typedef struct {
      int src;
      int last;
      int gap;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   last_beat_cyc = 0;
   int   beats_left [NC];
   int   bursts_left [NC];
   int   blen [NC];
   int   start_cyc [NC];
   bit   stall_en [NC];
   bit   toggle_rdy;
   bit   chk035;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_beat(input int src, input int last, input int gap);
      exp_t e;
      e.src  = src;
      e.last = last;
      e.gap  = gap;
      exp_q.push_back(e);
   endtask

   task automatic set_client(input int i, input int n, input int len, input int start);
      bursts_left[i] = n;
      blen[i]        = len;
      beats_left[i]  = (n != 0) ? len : 0;
      start_cyc[i]   = start;
      stall_en[i]    = 1'b0;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req_valid  = '0;
      req_last   = '0;
      out_ready  = 1'b1;
      toggle_rdy = 1'b0;
      chk035     = 1'b0;
      for (int i = 0; i < NC; i++) set_client(i, 0, 1, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n         = 1'b1;
      cyc           = 0;
      last_beat_cyc = 0;
   endtask

   task automatic drive_phase();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NC; i++) begin
         req_valid[i] = (beats_left[i] != 0) && (cyc >= start_cyc[i]) &&
                        !(stall_en[i] && (cyc % 5 == 3));
         req_last[i]  = (beats_left[i] == 1);
      end
      out_ready = toggle_rdy ? (cyc % 3 != 1) : 1'b1;
   endtask

   task automatic monitor_phase();
      exp_t e;
      @(negedge clk);
      if (chk035 && beats_left[1] != 0) begin
         check("035_other_ready", 32'(req_ready & 4'b1101), 0);
         if (busy) check("035_gnt_held", 32'(gnt), 32'h2);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_extra_beat", 32'(out_valid), 0);
         end else begin
            e = exp_q.pop_front();
            check("sb_src", 32'(out_src), e.src);
            check("sb_last", 32'(out_last), e.last);
            if (e.gap != 0) check("sb_gap", cyc - last_beat_cyc, e.gap);
         end
         last_beat_cyc = cyc;
      end
      for (int i = 0; i < NC; i++) begin
         if (req_valid[i] && req_ready[i] && beats_left[i] != 0) begin
            beats_left[i]--;
            if (beats_left[i] == 0) begin
               bursts_left[i]--;
               if (bursts_left[i] > 0) beats_left[i] = blen[i];
            end
         end
      end
   endtask

   task automatic step();
      drive_phase();
      monitor_phase();
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check({tag, "_drain"}, 32'(exp_q.size()), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state, with every requester active so the outputs are not trivially idle
      rst_n      = 1'b0;
      req_valid  = '1;
      req_last   = '1;
      out_ready  = 1'b1;
      cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
      #12;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_out_src", 32'(out_src), 0);
      check("rst_ptr", 32'(dut.ptr_q), 0);
      check("rst_cnt0", 32'(dut.cnt_q[0]), 0);

      // Single beat from client 0: refresh, then grant two cycles after request
      do_reset();
      cfg_weight = {4'd2, 4'd2, 4'd2, 4'd2};
      set_client(0, 1, 1, 0);
      push_beat(0, 1, 0);
      step();
      check("032_c1_gnt", 32'(gnt), 0);
      check("032_c1_busy", 32'(busy), 0);
      step();
      check("032_c2_gnt", 32'(gnt), 0);
      step();
      check("032_c3_gnt", 32'(gnt), 32'h1);
      check("032_c3_ready", 32'(req_ready), 32'h1);
      check("032_c3_valid", 32'(out_valid), 1);
      step();
      check("032_c4_gnt", 32'(gnt), 0);
      check("032_c4_busy", 32'(busy), 0);
      check("032_cnt0", 32'(dut.cnt_q[0]), 1);
      check("032_ptr", 32'(dut.ptr_q), 1);
      check("032_sb_empty", 32'(exp_q.size()), 0);

      // Equal weights, all clients: strict rotation with one idle cycle between bursts
      do_reset();
      cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
      for (int i = 0; i < NC; i++) set_client(i, 2, 1, 0);
      push_beat(0, 1, 0); push_beat(1, 1, 2); push_beat(2, 1, 2); push_beat(3, 1, 2);
      push_beat(0, 1, 3); push_beat(1, 1, 2); push_beat(2, 1, 2); push_beat(3, 1, 2);
      drain("033", 60);
      repeat (3) step();
      check("033_end_gnt", 32'(gnt), 0);
      check("033_end_busy", 32'(busy), 0);

      // Weights {3,1,0,1}: client 0 three times per round, client 2 masked forever
      do_reset();
      cfg_weight = {4'd1, 4'd0, 4'd1, 4'd3};
      set_client(0, 6, 1, 0);
      set_client(1, 2, 1, 0);
      set_client(2, 4, 1, 0);
      set_client(3, 2, 1, 0);
      push_beat(0, 1, 0); push_beat(1, 1, 2); push_beat(3, 1, 2); push_beat(0, 1, 2); push_beat(0, 1, 2);
      push_beat(1, 1, 3); push_beat(3, 1, 2); push_beat(0, 1, 2); push_beat(0, 1, 2); push_beat(0, 1, 2);
      drain("034", 80);
      repeat (12) step();
      check("034_masked_gnt", 32'(gnt), 0);
      check("034_masked_busy", 32'(busy), 0);
      check("034_cnt0_refresh", 32'(dut.cnt_q[0]), 3);
      check("034_cnt2", 32'(dut.cnt_q[2]), 0);

      // 4-beat burst with out_ready toggling and a req_valid gap
      do_reset();
      cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
      set_client(1, 1, 4, 0);
      stall_en[1] = 1'b1;
      set_client(2, 1, 1, 0);
      toggle_rdy = 1'b1;
      chk035     = 1'b1;
      push_beat(1, 0, 0); push_beat(1, 0, 0); push_beat(1, 0, 0); push_beat(1, 1, 0);
      push_beat(2, 1, 0);
      drain("035", 60);
      chk035     = 1'b0;
      toggle_rdy = 1'b0;

      // Reset during beat 2: burst abandoned at once, refresh before the next grant
      do_reset();
      set_client(1, 1, 4, 0);
      push_beat(1, 0, 0);
      repeat (3) step();
      drive_phase();
      #1;
      check("036_beat2_valid", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      check("036_rst_gnt", 32'(gnt), 0);
      check("036_rst_valid", 32'(out_valid), 0);
      check("036_rst_ready", 32'(req_ready), 0);
      check("036_rst_busy", 32'(busy), 0);
      req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("036_sb_pre", 32'(exp_q.size()), 0);
      push_beat(1, 0, 0); push_beat(1, 0, 1); push_beat(1, 1, 1);
      step();
      check("036_r1_gnt", 32'(gnt), 0);
      step();
      check("036_r2_gnt", 32'(gnt), 0);
      step();
      check("036_r3_gnt", 32'(gnt), 32'h2);
      drain("036", 30);

      // Client 3 last beat while client 0 starts requesting: pointer wraps to 0
      do_reset();
      set_client(2, 1, 1, 0);
      set_client(3, 1, 2, 0);
      set_client(0, 1, 1, 6);
      push_beat(2, 1, 0); push_beat(3, 0, 2); push_beat(3, 1, 1); push_beat(0, 1, 2);
      repeat (6) step();
      check("037_c6_gnt", 32'(gnt), 32'h8);
      check("037_c6_last", 32'(out_last), 1);
      check("037_c6_req0", 32'(req_valid[0]), 1);
      step();
      check("037_c7_gnt", 32'(gnt), 0);
      check("037_c7_busy", 32'(busy), 0);
      step();
      check("037_c8_gnt", 32'(gnt), 32'h1);
      drain("037", 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
